// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single memory port shared by fetch and load/store, one transaction at a time
// Optional round-robin arbitration between the two requesters: define MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic              owner_lsu;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_lsu, grant_ifu, timed_out;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
        grant_ifu = ifu_req_valid & (~lsu_req_valid | last_lsu);
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_lsu <= 1'b1;
        else if (state == IDLE && (grant_lsu || grant_ifu))
            last_lsu <= grant_lsu;
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid & ~lsu_req_valid;
    end
`endif

    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu)
                    state_nxt = REQ;
            end
            REQ: begin
                if (timed_out)
                    state_nxt = RESP;
                else if (mem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid || timed_out)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_lsu <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_ready) begin
                        owner_lsu <= 1'b1;
                        addr_q    <= lsu_addr;
                        wen_q     <= lsu_wen;
                        wdata_q   <= lsu_wdata;
                        wmask_q   <= lsu_wmask;
                        cnt       <= '0;
                    end else if (ifu_req_ready) begin
                        owner_lsu <= 1'b0;
                        addr_q    <= ifu_addr;
                        wen_q     <= 1'b0;
                        wdata_q   <= '0;
                        wmask_q   <= '0;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A genuine response wins over a timeout landing in the same cycle.
                    if (mem_resp_valid) begin
                        rdata_q <= wen_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_valid  = (state == REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign busy           = (state != IDLE);

    assign ifu_resp_valid = (state == RESP) & ~owner_lsu;
    assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
    assign ifu_resp_err   = ifu_resp_valid & err_q;
    assign lsu_resp_valid = (state == RESP) & owner_lsu;
    assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
    assign lsu_resp_err   = lsu_resp_valid & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

`ifdef MEM_ARB_RR_EN
    localparam bit TIE_FIRST_LSU = 1'b0;
`else
    localparam bit TIE_FIRST_LSU = 1'b1;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          delay;
        bit          respond;
    } mem_exp_t;

    typedef struct {
        bit          is_lsu;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int late_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: takes its behaviour for each request from mem_q and checks the held fields every REQ cycle.
    initial begin : mem_model
        int       m_cnt;
        bit       m_active;
        bit       m_resp;
        int       late_done;
        mem_exp_t cur;
        m_cnt = 0; m_active = 0; m_resp = 0; late_done = 0;
        cur = '{addr: 0, wen: 0, wdata: 0, wmask: 0, rdata: 0, delay: 0, respond: 0};
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            #1;
            mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
            if (rst) begin
                m_cnt = 0; m_active = 0; m_resp = 0;
            end else if (late_req != late_done) begin
                late_done = late_req;
                mem_resp_valid = 1; mem_rdata = 32'hBAD0BAD0;
            end else if (m_resp) begin
                m_resp = 0;
                if (cur.respond) begin
                    mem_resp_valid = 1; mem_rdata = cur.rdata;
                end
            end else if (mem_req_valid) begin
                if (!m_active) begin
                    if (mem_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL mem_unexpected_req: got addr 0x%0h want no request", mem_addr);
                        cur = '{addr: mem_addr, wen: mem_wen, wdata: mem_wdata, wmask: mem_wmask,
                                rdata: 0, delay: 0, respond: 0};
                    end else begin
                        cur = mem_q.pop_front();
                    end
                    m_active = 1; m_cnt = 0;
                end
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wen", mem_wen, cur.wen);
                chk("mem_wmask", mem_wmask, cur.wmask);
                if (cur.wen) chk("mem_wdata", mem_wdata, cur.wdata);
                if (m_cnt == cur.delay) begin
                    mem_req_ready = 1; m_resp = 1; m_active = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_active = 0;
            end
        end
    end

    // Response monitor: every resp pulse must match the head of resp_q.
    initial begin : monitor
        resp_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("ready_exclusive", {1'b0, ifu_req_ready & lsu_req_ready}, 0);
                if (ifu_resp_valid || lsu_resp_valid) begin
                    if (resp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL resp_unexpected: got ifu=%0b lsu=%0b want no response (cycle %0d)",
                                 ifu_resp_valid, lsu_resp_valid, cyc);
                    end else begin
                        e = resp_q.pop_front();
                        chk("resp_owner_ifu", ifu_resp_valid, !e.is_lsu);
                        chk("resp_owner_lsu", lsu_resp_valid, e.is_lsu);
                        chk("resp_rdata", e.is_lsu ? lsu_rdata : ifu_rdata, e.rdata);
                        chk("resp_err", e.is_lsu ? lsu_resp_err : ifu_resp_err, e.err);
                        chk("other_rdata", e.is_lsu ? ifu_rdata : lsu_rdata, 0);
                        chk("resp_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_mem(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                            input logic [3:0] wmask, input logic [31:0] rdata, input int delay,
                            input bit respond);
        mem_q.push_back('{addr: addr, wen: wen, wdata: wdata, wmask: wmask, rdata: rdata,
                          delay: delay, respond: respond});
    endtask

    task automatic push_resp(input bit is_lsu, input logic [31:0] rdata, input logic err, input int at);
        resp_q.push_back('{is_lsu: is_lsu, rdata: rdata, err: err, cyc: at});
    endtask

    task automatic drive_ifu(input logic [31:0] addr);
        ifu_addr = addr; ifu_req_valid = 1;
    endtask

    task automatic drive_lsu(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                             input logic [3:0] wmask);
        lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask; lsu_req_valid = 1;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic wait_ready(input bit lsu, input bit keep, output int acc);
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if ((lsu ? lsu_req_ready : ifu_req_ready) === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (acc < 0) begin
            n_bad++;
            $display("FAIL accept_%s: got no ready within 40 cycles want ready", lsu ? "lsu" : "ifu");
        end
        @(negedge clk);
        if (!keep) begin
            if (lsu) lsu_req_valid = 0;
            else ifu_req_valid = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        #1;
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
        chk({tag, "_resp_data"}, {ifu_rdata, lsu_rdata}, 0);
        chk({tag, "_resp_err"}, {ifu_resp_err, lsu_resp_err}, 0);
        chk({tag, "_ready"}, {ifu_req_ready, lsu_req_ready}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Both requesters raise valid together; the loser is served right after the winner's response.
    task automatic tie(input bit first_lsu);
        int a1, a2;
        if (first_lsu) begin
            push_mem(32'h80002000, 0, 0, 4'hF, 32'h22222222, 0, 1);
            push_mem(32'h80000100, 0, 0, 4'h0, 32'h11111111, 0, 1);
        end else begin
            push_mem(32'h80000100, 0, 0, 4'h0, 32'h11111111, 0, 1);
            push_mem(32'h80002000, 0, 0, 4'hF, 32'h22222222, 0, 1);
        end
        drive_ifu(32'h80000100);
        drive_lsu(32'h80002000, 0, 32'h0, 4'hF);
        wait_ready(first_lsu, 0, a1);
        push_resp(first_lsu, first_lsu ? 32'h22222222 : 32'h11111111, 0, a1 + 3);
        wait_ready(!first_lsu, 0, a2);
        push_resp(!first_lsu, first_lsu ? 32'h11111111 : 32'h22222222, 0, a2 + 3);
        chk("tie_second_accept_cycle", a2, a1 + 4);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish within 200000 time units");
        $fatal(1);
    end

    initial begin : stim
        int a1, a2;
        rst = 1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        idle_cycles(3);
        chk_quiet("reset");
        rst = 0;
        idle_cycles(1);
        chk_quiet("post_reset");

        tie(TIE_FIRST_LSU);
        tie(TIE_FIRST_LSU);

        // Lone fetch, zero-wait memory.
        push_mem(32'h80000000, 0, 0, 4'h0, 32'h00000413, 0, 1);
        drive_ifu(32'h80000000);
        wait_ready(0, 0, a1);
        push_resp(0, 32'h00000413, 0, a1 + 3);
        idle_cycles(3);

        // Store with memory ready delayed 3 cycles; read data of a store is 0.
        push_mem(32'h80001000, 1, 32'hDEADBEEF, 4'hF, 32'h12345678, 3, 1);
        drive_lsu(32'h80001000, 1, 32'hDEADBEEF, 4'hF);
        wait_ready(1, 0, a1);
        push_resp(1, 32'h0, 0, a1 + 6);
        idle_cycles(6);

        // Partial-mask load, one-cycle ready delay.
        push_mem(32'h80001004, 0, 32'h0, 4'h3, 32'hCAFEF00D, 1, 1);
        drive_lsu(32'h80001004, 0, 32'h0, 4'h3);
        wait_ready(1, 0, a1);
        push_resp(1, 32'hCAFEF00D, 0, a1 + 4);
        idle_cycles(4);

        // Fetch valid held through the whole transaction: next accept only once back in IDLE.
        push_mem(32'h80000008, 0, 0, 4'h0, 32'h0000A0A0, 0, 1);
        push_mem(32'h80000008, 0, 0, 4'h0, 32'h0000B0B0, 0, 1);
        drive_ifu(32'h80000008);
        wait_ready(0, 1, a1);
        push_resp(0, 32'h0000A0A0, 0, a1 + 3);
        wait_ready(0, 0, a2);
        push_resp(0, 32'h0000B0B0, 0, a2 + 3);
        chk("held_reaccept_cycle", a2, a1 + 4);
        idle_cycles(4);

        // Memory never ready: error response TO cycles after entering REQ, late response dropped.
        push_mem(32'h80000040, 0, 0, 4'h0, 32'h77777777, 1000, 1);
        drive_ifu(32'h80000040);
        wait_ready(0, 0, a1);
        push_resp(0, 32'h0, 1, a1 + 1 + TO);
        idle_cycles(TO + 3);
        late_req++;
        idle_cycles(5);

        // Reset during WAIT abandons the transaction.
        push_mem(32'h80003000, 0, 0, 4'hF, 32'h33333333, 0, 0);
        drive_lsu(32'h80003000, 0, 32'h0, 4'hF);
        wait_ready(1, 0, a1);
        @(negedge clk);
        #1;
        chk("wait_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        chk_quiet("mid_reset");
        rst = 0;
        idle_cycles(TO + 4);

        // Normal operation resumes after the abandoned transaction.
        push_mem(32'h80000004, 0, 0, 4'h0, 32'h00100093, 0, 1);
        drive_ifu(32'h80000004);
        wait_ready(0, 0, a1);
        push_resp(0, 32'h00100093, 0, a1 + 3);
        idle_cycles(6);

        chk("resp_queue_drained", resp_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch (read-only) and load/store (read/write) requesters in the multi-cycle core.
- Accepts one transaction at a time, forwards it to memory, and waits for the response. It then routes a one-cycle response pulse back to the owning requester.
- A response timeout stops a stalled memory from hanging the core.
- Sits between the fetch/load-store units and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- TIMEOUT, 255, cycles allowed in REQ+WAIT before an error response; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch response pulse
- ifu_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  load/store response pulse
- lsu_rdata  out  DATA_W  load data; 0 for stores
- lsu_resp_err  out  1  load/store timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  DATA_W/8  latched mask
- mem_resp_valid  in  1  memory response or write ack
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous and active-high, on clk.
  - In the cycle after reset, state=IDLE and all outputs are 0.
  - owner=IFU, last_grant=LSU, timeout counter=0.
  - Asserting rst mid-transaction abandons it; no response is issued.
- State IDLE: ready is combinational; at most one of ifu_req_ready/lsu_req_ready is high.
  - Default arbitration is fixed priority with LSU first: lsu_req_ready = lsu_req_valid; ifu_req_ready = ifu_req_valid & !lsu_req_valid.
  - On acceptance, latch addr, wen, wdata and wmask (IFU: wen=0, mask=0), record owner, clear the counter, and go to REQ.
- State REQ: mem_req_valid=1 with the latched fields.
  - mem_req_ready=1 -> WAIT.
  - Held fields stay stable until the handshake completes.
- State WAIT: mem_req_valid=0.
  - mem_resp_valid=1 -> latch mem_rdata (0 if the op is a write), err=0, go to RESP.
- Timeout: the counter increments each cycle in REQ or WAIT.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without leaving REQ/WAIT -> go to RESP with err=1 and rdata=0.
  - mem_req_valid drops in the next cycle.
- State RESP: the owner's resp_valid=1 for exactly one cycle, with the owner's rdata/err driven from the latches; the other requester's resp outputs are 0. Then go to IDLE.
- Ignored and dropped inputs:
  - mem_resp_valid in IDLE, REQ or RESP is ignored; a late response after a timeout is dropped.
  - Requester inputs outside IDLE are ignored (ready=0).
- Latency: accept in cycle N -> mem_req_valid in N+1. Zero-wait memory (ready in N+1, resp in N+2) -> resp_valid in N+3. Back-to-back accept is possible in N+4.
- Simultaneous requests in IDLE resolve by the arbitration rule. The loser's valid stays high and it is served after the winner completes.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are valid in IDLE, grant the one not equal to last_grant; a single valid requester is always granted. last_grant updates on every accept and resets to LSU, so IFU wins the first tie.
- Undefined: fixed LSU-first priority, and last_grant is not implemented.

Test Plan:
- IFU read alone, ifu_addr=0x80000000, memory zero-wait returning 0x00000413 -> ifu_req_ready in cycle N; mem_addr=0x80000000, mem_wen=0 in N+1; ifu_resp_valid pulse in N+3 with ifu_rdata=0x00000413, err=0.
- LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, memory ready delayed 3 cycles -> mem fields stable for all of REQ; lsu_resp_valid one cycle after the ack, lsu_rdata=0.
- Both requesters valid in the same IDLE cycle:
  - Fixed mode: LSU granted first, IFU granted in the cycle after the LSU response.
  - MEM_ARB_RR_EN: IFU first, then LSU, then IFU on the next tie.
- TIMEOUT=8, mem_resp_valid never asserted -> owner resp_valid with err=1 and rdata=0, 8 cycles after entering REQ. A late mem_resp_valid then produces no response.
- rst pulsed during WAIT -> all outputs 0 and busy=0 in the next cycle; no resp_valid ever issued for the dropped transaction.
- Requester valid held during RESP -> ready stays 0 until IDLE, then accept occurs; exactly one resp pulse per accept.
